propose_sequencer: RTL
======================

Name: propose_sequencer

Overview:
- Control FSM for one proposal step of the probabilistic-search propose datapath.
- On a start pulse, selects one of three paths from the latched variable type: boolean flip, continuous integer (per-clause reduce, then segment select), or discrete (sizes / random / values-table).
- Asserts the matching per-stage enables, then the sampler enables for the configured latency, then pulses done.
- Sits between the probabilistic-search control unit and the propose datapath.

Parameters:
- MAX_BIT_WIDTH_OF_CLAUSES_INDEX, 3: clause index width; 2**N clause slots.
- SAMPLER_LATENCY, 1: cycles the sampler enable is held per proposal; legal range 1..15.

Ports:
- in_clock  input  1  system clock, rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_start  input  1  request one proposal; accepted only in IDLE.
- in_abort  input  1  synchronous abort; returns the FSM to IDLE.
- in_variable_type  input  2  type of the variable to change: 0 boolean, 1 continuous integer, 2 discrete, 3 reserved. Latched at start.
- in_num_clauses  input  N+1  number of active clauses (0..2**N). Latched at start.
- in_no_need_to_sample  input  1  equal-range flag from the discrete range randomizer.
- out_boolean_propose_enable  output  1  boolean propose stage enable.
- out_reduce_enable  output  2**N  one-hot per-clause reduce enable.
- out_select_segment_enable  output  1  segment select enable.
- out_DiscreteVariablesSizes_enable  output  1  discrete stage enable.
- out_random_enable  output  1  discrete stage enable.
- out_DiscreteValuesTable_enable  output  1  discrete stage enable.
- out_sampler_enable  output  1  sampler enable.
- out_chosen_variable_is_discrete  output  1  sampler source select; held between proposals.
- out_busy  output  1  high in every state except IDLE.
- out_done  output  1  one-cycle completion pulse.
- out_error  output  1  one-cycle pulse, co-asserted with out_done, when the reserved type is requested.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, all counters = 0.
  - Every output = 0, including out_chosen_variable_is_discrete.
  - Reset mid-operation abandons the proposal; no done pulse is produced.
- Outputs are Moore-decoded from registered state and counters; no combinational path from any input to any output.
- States: IDLE, BOOL, REDUCE, SELECT, DSIZE, DRAND, DTABLE, DCHECK, SAMPLE, DONE.
- IDLE:
  - When in_start=1: latch type and num_clauses (values above 2**N clamp to 2**N).
  - Load out_chosen_variable_is_discrete = (type==2).
  - Next state: type 0 -> BOOL; 1 -> REDUCE, or SELECT if num_clauses==0; 2 -> DSIZE; 3 -> DONE with error flag set.
  - in_start outside IDLE is ignored; it is neither queued nor an error.
- BOOL: out_boolean_propose_enable=1 for 1 cycle -> DONE.
- REDUCE:
  - Clause counter k runs 0..num_clauses-1; out_reduce_enable = 1<<k, one cycle per clause.
  - After the last clause -> SELECT.
- SELECT: out_select_segment_enable=1 for 1 cycle -> SAMPLE.
- Discrete path:
  - DSIZE, DRAND and DTABLE each assert their own enable for 1 cycle, in that order.
  - DCHECK (no enables): samples in_no_need_to_sample. 1 -> DONE, sampler skipped; 0 -> SAMPLE.
- SAMPLE: out_sampler_enable=1 for exactly SAMPLER_LATENCY cycles (down-counter) -> DONE.
- DONE: out_done=1 (out_error=1 if reserved type) for 1 cycle -> IDLE. A new start can be accepted in the next cycle.
- Latency, counted from the start-accept edge (cycle 0) to the out_done cycle:
  - boolean: 2.
  - continuous: num_clauses + SAMPLER_LATENCY + 2.
  - discrete, sampled: 5 + SAMPLER_LATENCY.
  - discrete, no sample: 5.
  - reserved: 1.
- in_abort=1 in any non-IDLE state:
  - Next state IDLE, all enables deasserted next cycle, no done.
  - Abort takes priority over all transitions.
  - Abort in IDLE, including simultaneous with in_start, is ignored: the start is accepted.
- At most one enable output is high in any cycle (the one-hot reduce vector counts as one).
- out_chosen_variable_is_discrete changes only at start accept or reset.

Decomposition:
- Package propose_pkg holds:
  - State encoding.
  - Variable type constants: TYPE_BOOLEAN=0, TYPE_CONTINUOUS=1, TYPE_DISCRETE=2.
  - Segment type constant UNIFORM=3.
- One sub-module, clause_enable_counter: clause counter plus one-hot decoder, producing out_reduce_enable and a last-clause flag.

Test Plan:
- Reset, then boolean start -> enable high in cycle 1 only; out_done in cycle 2; out_busy high in cycles 1-2; all other enables stay 0.
- Continuous, num_clauses=3, SAMPLER_LATENCY=1 -> reduce_enable 0x01, 0x02, 0x04 in cycles 1-3; select in 4; sampler in 5; done in 6.
- Continuous, num_clauses=0 -> select in cycle 1, sampler in 2, done in 3; num_clauses=9 with N=3 -> clamps to 8 reduce cycles, last 0x80.
- Discrete, no_need=0, SAMPLER_LATENCY=2 -> sizes/random/table in cycles 1/2/3, sampler in 6-7, done in 7? no: sampler in 5-6, done in 7; is_discrete=1 from cycle 1. With no_need=1 -> no sampler, done in 5.
- Abort in REDUCE cycle 2 -> IDLE next cycle, no done, enables 0. Async reset in SAMPLE -> outputs 0 immediately. Start while busy -> ignored, single done.
- Type 3 -> done and error both high in cycle 1, no enables; back-to-back boolean starts -> done every 3 cycles.

Source files
------------

// File: rtl/propose_pkg.sv
// Shared encodings for the propose sequencer: FSM states, variable types and
// the segment-type constant the datapath uses.
package propose_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_BOOL   = 4'd1,
    S_REDUCE = 4'd2,
    S_SELECT = 4'd3,
    S_DSIZE  = 4'd4,
    S_DRAND  = 4'd5,
    S_DTABLE = 4'd6,
    S_DCHECK = 4'd7,
    S_SAMPLE = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  localparam logic [1:0] TYPE_BOOLEAN    = 2'd0;
  localparam logic [1:0] TYPE_CONTINUOUS = 2'd1;
  localparam logic [1:0] TYPE_DISCRETE   = 2'd2;

  localparam logic [1:0] UNIFORM = 2'd3;

endpackage

// File: rtl/propose_sequencer_clause_enable_counter.sv
// Clause counter for the REDUCE phase: steps one clause per active cycle and
// decodes the current clause to a one-hot reduce enable.
module clause_enable_counter #(
  parameter int N = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_active,
  input  logic [N:0]         i_num,
  output logic [(1<<N)-1:0]  o_enable,
  output logic               o_last
);
  localparam int SLOTS = 1 << N;

  logic [N-1:0] r_k;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_k <= '0;
    else if (i_clear)  r_k <= '0;
    else if (i_active) r_k <= r_k + {{(N-1){1'b0}}, 1'b1};
  end

  assign o_enable = i_active ? (SLOTS'(1) << r_k) : '0;
  assign o_last   = ({1'b0, r_k} == (i_num - {{N{1'b0}}, 1'b1}));

endmodule

// File: rtl/propose_sequencer.sv
// Control FSM for one proposal step: picks the boolean, continuous or discrete
// path from the latched type, walks its stage enables, runs the sampler, pulses done.
module propose_sequencer
  import propose_pkg::*;
#(
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
  parameter int SAMPLER_LATENCY                = 1
) (
  input  logic                                         in_clock,
  input  logic                                         in_reset,
  input  logic                                         in_start,
  input  logic                                         in_abort,
  input  logic [1:0]                                   in_variable_type,
  input  logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0]      in_num_clauses,
  input  logic                                         in_no_need_to_sample,
  output logic                                         out_boolean_propose_enable,
  output logic [(1<<MAX_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] out_reduce_enable,
  output logic                                         out_select_segment_enable,
  output logic                                         out_DiscreteVariablesSizes_enable,
  output logic                                         out_random_enable,
  output logic                                         out_DiscreteValuesTable_enable,
  output logic                                         out_sampler_enable,
  output logic                                         out_chosen_variable_is_discrete,
  output logic                                         out_busy,
  output logic                                         out_done,
  output logic                                         out_error
);
  localparam int N     = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int SLOTS = 1 << N;
  localparam logic [N:0] MAX_CL  = (N+1)'(SLOTS);
  localparam logic [3:0] SAMP_LD = 4'(SAMPLER_LATENCY);

  state_t     r_state, w_next;
  logic [N:0] r_num;
  logic       r_err;
  logic       r_disc;
  logic [3:0] r_samp;
  logic       w_accept;
  logic [N:0] w_num_clamped;
  logic       w_last;

  assign w_accept      = (r_state == S_IDLE) && in_start;
  assign w_num_clamped = (in_num_clauses > MAX_CL) ? MAX_CL : in_num_clauses;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_err   <= 1'b0;
      r_disc  <= 1'b0;
      r_samp  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_num  <= w_num_clamped;
        r_err  <= (in_variable_type == UNIFORM);
        r_disc <= (in_variable_type == TYPE_DISCRETE);
      end
      // Load on entry so the sampler enable lasts exactly SAMPLER_LATENCY cycles.
      if (w_next == S_SAMPLE && r_state != S_SAMPLE) r_samp <= SAMP_LD;
      else if (r_state == S_SAMPLE)                  r_samp <= r_samp - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_start) begin
        case (in_variable_type)
          TYPE_BOOLEAN:    w_next = S_BOOL;
          TYPE_CONTINUOUS: w_next = (w_num_clamped == '0) ? S_SELECT : S_REDUCE;
          TYPE_DISCRETE:   w_next = S_DSIZE;
          default:         w_next = S_DONE;
        endcase
      end
      S_BOOL:   w_next = S_DONE;
      S_REDUCE: if (w_last) w_next = S_SELECT;
      S_SELECT: w_next = S_SAMPLE;
      S_DSIZE:  w_next = S_DRAND;
      S_DRAND:  w_next = S_DTABLE;
      S_DTABLE: w_next = S_DCHECK;
      S_DCHECK: w_next = in_no_need_to_sample ? S_DONE : S_SAMPLE;
      S_SAMPLE: if (r_samp == 4'd1) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (in_abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  clause_enable_counter #(.N(N)) u_clause (
    .i_clk    (in_clock),
    .i_rst    (in_reset),
    .i_clear  (w_accept),
    .i_active (r_state == S_REDUCE),
    .i_num    (r_num),
    .o_enable (out_reduce_enable),
    .o_last   (w_last)
  );

  assign out_boolean_propose_enable        = (r_state == S_BOOL);
  assign out_select_segment_enable         = (r_state == S_SELECT);
  assign out_DiscreteVariablesSizes_enable = (r_state == S_DSIZE);
  assign out_random_enable                 = (r_state == S_DRAND);
  assign out_DiscreteValuesTable_enable    = (r_state == S_DTABLE);
  assign out_sampler_enable                = (r_state == S_SAMPLE);
  assign out_chosen_variable_is_discrete   = r_disc;
  assign out_busy                          = (r_state != S_IDLE);
  assign out_done                          = (r_state == S_DONE);
  assign out_error                         = (r_state == S_DONE) && r_err;

endmodule
